// File: rtl/gb_timer_regs_pkg.sv
// rtl/gb_timer_regs_pkg.sv - shared types and constants for the Game Boy timer block
//
// Purpose : register offsets inside the 4-byte timer window, the reload state
//           type, and the TAC clock-select to divider-bit mapping.
// Ports   : none (package).

package gb_timer_types;

   // Byte offsets from BASE_ADDR.
   localparam logic [1:0] OFF_DIV  = 2'd0;
   localparam logic [1:0] OFF_TIMA = 2'd1;
   localparam logic [1:0] OFF_TMA  = 2'd2;
   localparam logic [1:0] OFF_TAC  = 2'd3;

   typedef enum logic {
      RUN    = 1'b0,
      RELOAD = 1'b1
   } timer_state_t;

   // TAC[1:0] -> div_cnt bit whose falling edge clocks TIMA.
   // 00 -> 4096 Hz, 01 -> 262144 Hz, 10 -> 65536 Hz, 11 -> 16384 Hz.
   localparam logic [3:0] TAC_BIT_IDX [4] = '{4'd9, 4'd3, 4'd5, 4'd7};

   // Unused TAC bits read back as ones.
   function automatic logic [7:0] tac_readback(input logic [2:0] tac);
      return {5'b11111, tac};
   endfunction

endpackage

// File: rtl/gb_timer_regs_edge_sel.sv
// rtl/gb_timer_regs_edge_sel.sv - TIMA clock source: divider bit select and falling-edge detect
//
// Purpose : picks the divider bit named by TAC[1:0], gates it with the TAC
//           enable, and reports a one-cycle tick when that gated bit falls.
// Ports   : clk     - T-cycle clock
//           rst_n   - asynchronous active-low reset
//           div_cnt - current internal 16-bit divider
//           tac     - timer control (enable + clock select)
//           tick    - high for the cycle in which the gated bit has just fallen

module timer_edge_sel
   import gb_timer_types::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] div_cnt,
   input  logic [2:0]  tac,
   output logic        tick
);

   logic sel_bit;
   logic prev_bit;

   // The enable is ANDed in before edge detection, so clearing TAC[2] while
   // the selected bit is high looks like a falling edge. DIV writes behave
   // the same way. Hardware-faithful, so kept deliberately.
   assign sel_bit = div_cnt[TAC_BIT_IDX[tac[1:0]]] & tac[2];
   assign tick    = prev_bit & ~sel_bit;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev_bit <= 1'b0;
      end else begin
         prev_bit <= sel_bit;
      end
   end

endmodule

// File: rtl/gb_timer_regs.sv
// rtl/gb_timer_regs.sv - Game Boy DIV/TIMA/TMA/TAC timer with CPU register access
//
// Purpose : 16-bit free-running divider, 8-bit TIMA counter clocked by a
//           selectable divider edge, TMA reload with one-cycle delay and a
//           single-cycle timer interrupt request on overflow.
// Ports   : clk       - T-cycle clock (4.194304 MHz)
//           rst_n     - asynchronous active-low reset
//           addr      - bus address, window BASE_ADDR..BASE_ADDR+3
//           wr_data   - bus write data
//           wr_en     - one-cycle write strobe
//           rd_en     - one-cycle read strobe
//           rd_data   - read data, valid the cycle after rd_en
//           rd_valid  - high the cycle after an rd_en that hit the window
//           irq_timer - one-cycle interrupt request (IF bit 2 source)

module gb_timer_regs
   import gb_timer_types::*;
#(
   parameter logic [15:0] BASE_ADDR = 16'hFF04,
   parameter logic [15:0] DIV_RESET = 16'h0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] addr,
   input  logic [7:0]  wr_data,
   input  logic        wr_en,
   input  logic        rd_en,
   output logic [7:0]  rd_data,
   output logic        rd_valid,
   output logic        irq_timer
);

   logic [15:0]  div_cnt;
   logic [7:0]   tima;
   logic [7:0]   tma;
   logic [2:0]   tac;
   timer_state_t state;
   logic         tick;

   // Address decode: subtracting the base keeps this correct for any
   // BASE_ADDR, aligned or not.
   logic [15:0] off_full;
   logic [1:0]  off;
   logic        hit;

   assign off_full = addr - BASE_ADDR;
   assign off      = off_full[1:0];
   assign hit      = (off_full[15:2] == 14'd0);

   logic wr_div;
   logic wr_tima;
   logic wr_tma;
   logic wr_tac;

   assign wr_div  = wr_en & hit & (off == OFF_DIV);
   assign wr_tima = wr_en & hit & (off == OFF_TIMA);
   assign wr_tma  = wr_en & hit & (off == OFF_TMA);
   assign wr_tac  = wr_en & hit & (off == OFF_TAC);

   timer_edge_sel u_edge_sel (
      .clk     (clk),
      .rst_n   (rst_n),
      .div_cnt (div_cnt),
      .tac     (tac),
      .tick    (tick)
   );

   // Divider: any DIV write clears it, data ignored.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt <= DIV_RESET;
      end else if (wr_div) begin
         div_cnt <= 16'h0000;
      end else begin
         div_cnt <= div_cnt + 16'd1;
      end
   end

   // TMA and TAC are plain registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tma <= 8'h00;
         tac <= 3'b000;
      end else begin
         if (wr_tma) begin
            tma <= wr_data;
         end
         if (wr_tac) begin
            tac <= wr_data[2:0];
         end
      end
   end

   // TIMA and reload sequencing. Overflow leaves TIMA at 0x00 for one cycle
   // (RELOAD), during which TMA is copied in and irq_timer is high.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= RUN;
         tima      <= 8'h00;
         irq_timer <= 1'b0;
      end else begin
         irq_timer <= 1'b0;
         case (state)
            RUN: begin
               // A CPU write beats any tick, including the one that would
               // overflow, so the overflow is cancelled outright.
               if (wr_tima) begin
                  tima <= wr_data;
               end else if (tick) begin
                  if (tima == 8'hFF) begin
                     tima      <= 8'h00;
                     state     <= RELOAD;
                     irq_timer <= 1'b1;
                  end else begin
                     tima <= tima + 8'd1;
                  end
               end
            end
            RELOAD: begin
               // TIMA writes and ticks are dropped here; a TMA write in this
               // cycle goes straight through to TIMA as well.
               tima  <= wr_tma ? wr_data : tma;
               state <= RUN;
            end
         endcase
      end
   end

   // Read path: captures pre-write register values, so a simultaneous
   // read+write returns the old contents.
   logic [7:0] rd_mux;

   always_comb begin
      rd_mux = 8'h00;
      case (off)
         OFF_DIV:  rd_mux = div_cnt[15:8];
         OFF_TIMA: rd_mux = tima;
         OFF_TMA:  rd_mux = tma;
         default:  rd_mux = tac_readback(tac);
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_data  <= 8'h00;
         rd_valid <= 1'b0;
      end else if (rd_en && hit) begin
         rd_data  <= rd_mux;
         rd_valid <= 1'b1;
      end else begin
         rd_data  <= 8'h00;
         rd_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_gb_timer_regs.sv
// tb/tb_gb_timer_regs.sv - directed self-checking bench for gb_timer_regs

module tb_gb_timer_regs;

   logic        clk;
   logic        rst_n;
   logic [15:0] addr;
   logic [7:0]  wr_data;
   logic        wr_en;
   logic        rd_en;
   logic [7:0]  rd_data;
   logic        rd_valid;
   logic        irq_timer;

   int pass_cnt  = 0;
   int total_cnt = 0;
   int irq_cnt   = 0;
   int irq_base;

   logic [7:0] d;
   logic       v;

   localparam logic [15:0] A_DIV  = 16'hFF04;
   localparam logic [15:0] A_TIMA = 16'hFF05;
   localparam logic [15:0] A_TMA  = 16'hFF06;
   localparam logic [15:0] A_TAC  = 16'hFF07;

   gb_timer_regs dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .addr      (addr),
      .wr_data   (wr_data),
      .wr_en     (wr_en),
      .rd_en     (rd_en),
      .rd_data   (rd_data),
      .rd_valid  (rd_valid),
      .irq_timer (irq_timer)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Counts clock cycles in which irq_timer was high.
   always @(posedge clk) begin
      if (irq_timer === 1'b1) irq_cnt <= irq_cnt + 1;
   end

   task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   // All bus tasks start and end on a negedge; each consumes one posedge.
   task automatic bus_write(input logic [15:0] a, input logic [7:0] dat);
      addr = a; wr_data = dat; wr_en = 1'b1;
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   task automatic bus_read(input logic [15:0] a, output logic [7:0] dat, output logic val);
      addr = a; rd_en = 1'b1;
      @(negedge clk);
      rd_en = 1'b0;
      dat = rd_data; val = rd_valid;
   endtask

   task automatic bus_rw(input logic [15:0] a, input logic [7:0] dat, output logic [7:0] q, output logic val);
      addr = a; wr_data = dat; wr_en = 1'b1; rd_en = 1'b1;
      @(negedge clk);
      wr_en = 1'b0; rd_en = 1'b0;
      q = rd_data; val = rd_valid;
   endtask

   task automatic read_chk(input string tag, input logic [15:0] a, input logic [7:0] exp);
      logic [7:0] q;
      logic       qv;
      bus_read(a, q, qv);
      check8({tag, "_data"}, q, exp);
      check8({tag, "_valid"}, {7'd0, qv}, 8'h01);
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b0; addr = 16'h0000; wr_data = 8'h00; wr_en = 1'b0; rd_en = 1'b0;
      repeat (3) @(negedge clk);

      // Reset state
      check8("rst_rd_data", rd_data, 8'h00);
      check8("rst_rd_valid", {7'd0, rd_valid}, 8'h00);
      check8("rst_irq", {7'd0, irq_timer}, 8'h00);
      rst_n = 1'b1;

      // 256 cycles after reset DIV = div_cnt[15:8] = 0x01
      idle(256);
      read_chk("div_256", A_DIV, 8'h01);
      read_chk("tac_rst", A_TAC, 8'hF8);
      read_chk("tima_rst", A_TIMA, 8'h00);
      read_chk("tma_rst", A_TMA, 8'h00);
      bus_read(16'hFF08, d, v);
      check8("miss_hi_valid", {7'd0, v}, 8'h00);
      check8("miss_hi_data", d, 8'h00);
      bus_read(16'hFF03, d, v);
      check8("miss_lo_valid", {7'd0, v}, 8'h00);
      check8("miss_lo_data", d, 8'h00);
      bus_rw(A_TMA, 8'h77, d, v);
      check8("rw_old_data", d, 8'h00);
      check8("rw_valid", {7'd0, v}, 8'h01);
      read_chk("rw_new_tma", A_TMA, 8'h77);
      bus_write(A_TAC, 8'hFC);
      read_chk("tac_upper_drop", A_TAC, 8'hFC);

      // Counting at bit 3: ticks on edges where div_cnt = 16,32,...
      bus_write(A_TAC, 8'h00);
      bus_write(A_DIV, 8'h5A);     // div -> 0
      bus_write(A_TAC, 8'h05);     // div -> 1
      bus_write(A_TIMA, 8'h00);    // div -> 2
      idle(160);                   // div 2..161: 10 ticks
      read_chk("tima_count", A_TIMA, 8'h0A);
      check8("no_irq_count", irq_cnt[7:0], 8'h00);

      // Overflow and reload
      irq_base = irq_cnt;
      bus_write(A_TAC, 8'h00);
      bus_write(A_DIV, 8'h00);     // div -> 0
      bus_write(A_TMA, 8'hAB);     // div -> 1
      bus_write(A_TIMA, 8'hFF);    // div -> 2
      bus_write(A_TAC, 8'h05);     // div -> 3
      idle(14);                    // overflow at div 16, now in RELOAD
      check8("irq_high", {7'd0, irq_timer}, 8'h01);
      read_chk("tima_wrap_zero", A_TIMA, 8'h00);
      read_chk("tima_reloaded", A_TIMA, 8'hAB);
      check8("irq_low_after", {7'd0, irq_timer}, 8'h00);
      idle(4);
      check8("irq_once", irq_cnt[7:0] - irq_base[7:0], 8'h01);

      // Write in the overflow cycle cancels the overflow
      irq_base = irq_cnt;
      bus_write(A_TAC, 8'h00);
      bus_write(A_DIV, 8'h00);     // div -> 0
      bus_write(A_TMA, 8'hAB);     // div -> 1
      bus_write(A_TIMA, 8'hFF);    // div -> 2
      bus_write(A_TAC, 8'h05);     // div -> 3
      idle(13);                    // div -> 16
      bus_write(A_TIMA, 8'h33);    // lands on the wrapping tick
      read_chk("ovf_write_wins", A_TIMA, 8'h33);
      check8("ovf_write_no_irq", irq_cnt[7:0] - irq_base[7:0], 8'h00);
      // TIMA write during RELOAD is ignored
      bus_write(A_TIMA, 8'hFF);    // div -> 19
      idle(14);                    // wrap at 32, now in RELOAD
      bus_write(A_TIMA, 8'h44);
      read_chk("reload_ignores_tima", A_TIMA, 8'hAB);
      check8("reload_irq", irq_cnt[7:0] - irq_base[7:0], 8'h01);
      // TMA write during RELOAD feeds both TMA and TIMA
      bus_write(A_TIMA, 8'hFF);    // div -> 36
      idle(13);                    // wrap at 48, now in RELOAD
      bus_write(A_TMA, 8'h5C);
      read_chk("reload_tma_to_tima", A_TIMA, 8'h5C);
      read_chk("reload_tma_stored", A_TMA, 8'h5C);
      check8("reload_irq2", irq_cnt[7:0] - irq_base[7:0], 8'h02);

      // Spurious ticks from DIV write and TAC disable
      bus_write(A_TAC, 8'h00);
      bus_write(A_DIV, 8'h00);     // div -> 0
      bus_write(A_TIMA, 8'h10);    // div -> 1
      bus_write(A_TAC, 8'h05);     // div -> 2
      idle(6);                     // div -> 8, bit 3 high
      bus_write(A_DIV, 8'h00);     // bit falls -> tick
      bus_read(A_TIMA, d, v);
      read_chk("spur_div", A_TIMA, 8'h11);
      idle(6);                     // div -> 8
      bus_write(A_TAC, 8'h00);
      bus_read(A_TIMA, d, v);
      read_chk("spur_tac", A_TIMA, 8'h12);
      idle(40);
      read_chk("disabled_hold", A_TIMA, 8'h12);

      // Reset while in RELOAD
      bus_write(A_TAC, 8'h00);
      bus_write(A_DIV, 8'h00);     // div -> 0
      bus_write(A_TIMA, 8'hFF);    // div -> 1
      bus_write(A_TAC, 8'h05);     // div -> 2
      idle(14);                    // div -> 16
      irq_base = irq_cnt;
      @(posedge clk);              // overflow edge, enter RELOAD
      #1 rst_n = 1'b0;
      #1;
      check8("rr_irq", {7'd0, irq_timer}, 8'h00);
      check8("rr_valid", {7'd0, rd_valid}, 8'h00);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      read_chk("rr_tima", A_TIMA, 8'h00);   // div -> 1
      read_chk("rr_div0", A_DIV, 8'h00);    // div -> 2
      idle(253);                            // div -> 255
      read_chk("rr_div255", A_DIV, 8'h00);
      read_chk("rr_div256", A_DIV, 8'h01);
      read_chk("rr_tma", A_TMA, 8'h00);
      read_chk("rr_tac", A_TAC, 8'hF8);
      check8("rr_irq_suppressed", irq_cnt[7:0] - irq_base[7:0], 8'h00);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
